// File: rtl/code_loader.sv
// -----------------------------------------------------------------------------
// code_loader
//
// Receives a framed program image over a byte stream and writes it into the
// processor's code memory, then releases the processor with `run`.
//
// Frame on the wire:  A5, LEN_HI, LEN_LO, {HI, LO} x N, CHK
//   N   = {LEN_HI[0], LEN_LO} + 1   (1..512 words, LEN_HI[7:1] must be 0)
//   CHK = 8-bit sum of all HI/LO data bytes
//
// Handshake: a byte is consumed on a rising clk edge where rx_valid and
// rx_ready are both 1. rx_ready depends only on the current state, never on
// rx_valid, so a source may hold rx_valid high across stalled cycles.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   rx_valid, rx_data  byte offered by the serial receiver
//   rx_ready           loader can take a byte this cycle
//   code_w_en          one-cycle code-memory write strobe
//   code_addr_in       code-memory write address (holds between writes)
//   code_in            code-memory write word (holds between writes)
//   run                processor run enable (only after a good frame)
//   busy               frame in progress
//   error              frame rejected; sticky until reset
//   dbg_state          current FSM state, for checkers and debug
// -----------------------------------------------------------------------------
module code_loader #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        code_w_en,
  output logic [8:0]  code_addr_in,
  output logic [15:0] code_in,
  output logic        run,
  output logic        busy,
  output logic        error,
  output logic [3:0]  dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LEN_HI  = 4'd1;
  localparam logic [3:0] S_LEN_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_CHK     = 4'd6;
  localparam logic [3:0] S_RUN     = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0]    state;
  logic [8:0]    count;   // N - 1, compared against the word index
  logic [8:0]    index;
  logic [7:0]    csum;
  logic [TW-1:0] tmo;
  logic          accept;
  logic          timed;
  logic          tmo_hit;

  assign dbg_state = state;

  // All status outputs decode straight from the state register, so an
  // asynchronous reset drops run and code_w_en without waiting for a clock.
  always_comb begin
    rx_ready  = 1'b0;
    code_w_en = 1'b0;
    run       = 1'b0;
    busy      = 1'b0;
    error     = 1'b0;
    case (state)
      S_IDLE: rx_ready = 1'b1;
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        code_w_en = 1'b1;
        busy      = 1'b1;
      end
      S_RUN: run = 1'b1;
      S_ERR: error = 1'b1;
      default: ;
    endcase
  end

  assign accept = rx_valid & rx_ready;
  // States that wait on the sender; WRITE counts idle time but never expires.
  assign timed  = busy & ~code_w_en;
  // '>=' rather than '==': the counter may step past TMO_LAST during WRITE.
  assign tmo_hit = timed & ~accept & (tmo >= TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      count        <= '0;
      index        <= '0;
      csum         <= '0;
      tmo          <= '0;
      code_addr_in <= '0;
      code_in      <= '0;
    end else begin
      if (accept || !busy) tmo <= '0;
      else                 tmo <= tmo + TW'(1);

      if (tmo_hit) begin
        state <= S_ERR;
      end else begin
        case (state)
          S_IDLE:
            if (accept && rx_data == 8'hA5) state <= S_LEN_HI;
          S_LEN_HI:
            if (accept) begin
              if (rx_data[7:1] != 7'd0) begin
                state <= S_ERR;
              end else begin
                count[8] <= rx_data[0];
                state    <= S_LEN_LO;
              end
            end
          S_LEN_LO:
            if (accept) begin
              count[7:0] <= rx_data;
              index      <= '0;
              csum       <= '0;
              state      <= S_DATA_HI;
            end
          S_DATA_HI:
            if (accept) begin
              code_in[15:8] <= rx_data;
              csum          <= csum + rx_data;
              state         <= S_DATA_LO;
            end
          S_DATA_LO:
            if (accept) begin
              code_in[7:0] <= rx_data;
              csum         <= csum + rx_data;
              // Separate address register so the address presented during
              // WRITE survives the index increment that follows it.
              code_addr_in <= index;
              state        <= S_WRITE;
            end
          S_WRITE:
            if (index == count) begin
              state <= S_CHK;
            end else begin
              index <= index + 9'd1;
              state <= S_DATA_HI;
            end
          S_CHK:
            if (accept) state <= (rx_data == csum) ? S_RUN : S_ERR;
          default: ;  // RUN and ERR hold until reset
        endcase
      end
    end
  end

endmodule
